// File: rtl/sad_stream_min.sv
// sad_stream_min: row-serial block SAD over a candidate search, tracking the minimum SAD and its index.
module sad_stream_min #(
  parameter int BLK_W = 4,
  parameter int BLK_H = 4,
  parameter int PIX_W = 8,
  parameter int IDX_W = 16,
  localparam int SAD_W = PIX_W + $clog2(BLK_W*BLK_H)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BLK_W*PIX_W-1:0] crop_row,
  input  logic [BLK_W*PIX_W-1:0] win_row,
  input  logic                   search_last,
  output logic [SAD_W-1:0]       sad_val,
  output logic                   sad_valid,
  output logic [IDX_W-1:0]       sad_idx,
  output logic [SAD_W-1:0]       min_sad,
  output logic [IDX_W-1:0]       min_idx,
  output logic                   done,
  output logic                   busy
);
  localparam int RW = $clog2(BLK_H);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DR1 = 2'd2, DR2 = 2'd3;
  logic [1:0] st;
  logic [RW-1:0] row;
  logic [IDX_W-1:0] cand;
  logic [SAD_W-1:0] row_sum, s1_rs, acc;
  logic [PIX_W:0] diff [BLK_W];
  logic [PIX_W:0] ad [BLK_W];
  logic s1_v, s1_last, accept, last_row;
  assign in_ready = st == RUN;
  assign busy = st != IDLE;
  assign accept = in_valid && in_ready;
  assign last_row = row == RW'(BLK_H-1);
  always_comb begin
    row_sum = '0;
    for (int c = 0; c < BLK_W; c++) begin
      diff[c] = {1'b0, crop_row[c*PIX_W +: PIX_W]} - {1'b0, win_row[c*PIX_W +: PIX_W]};
      ad[c] = diff[c][PIX_W] ? -diff[c] : diff[c];
      row_sum = row_sum + SAD_W'(ad[c]);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      row <= '0;
      cand <= '0;
      s1_rs <= '0;
      s1_v <= 1'b0;
      s1_last <= 1'b0;
      acc <= '0;
      sad_val <= '0;
      sad_valid <= 1'b0;
      sad_idx <= '0;
      min_sad <= '1;
      min_idx <= '0;
      done <= 1'b0;
    end else begin
      s1_v <= accept;
      s1_last <= accept && last_row;
      sad_valid <= 1'b0;
      done <= 1'b0;
      if (accept) s1_rs <= row_sum;
      if (st == IDLE && start) begin
        st <= RUN;
        min_sad <= '1;
        min_idx <= '0;
        cand <= '0;
      end
      if (accept) begin
        row <= last_row ? '0 : row + RW'(1);
        if (last_row && search_last) st <= DR1;
      end
      if (st == DR1) st <= DR2;
      if (st == DR2) begin
        st <= IDLE;
        done <= 1'b1;
      end
      // the accumulator is cleared in the same edge that publishes the block total
      if (s1_v) begin
        acc <= s1_last ? '0 : acc + s1_rs;
        if (s1_last) begin
          sad_val <= acc + s1_rs;
          sad_valid <= 1'b1;
          sad_idx <= cand;
          cand <= cand + IDX_W'(1);
        end
      end
      if (sad_valid && sad_val < min_sad) begin
        min_sad <= sad_val;
        min_idx <= sad_idx;
      end
    end
  end
endmodule

// File: tb/tb_sad_stream_min.sv
// tb_sad_stream_min: random and directed block streams on a 4x4 and an 8x8 instance, checked against a plain SAD/min model.
module tb_sad_stream_min;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic start4 = 0, v4 = 0, sl4 = 0, rdy4, sv4, dn4, bz4;
  logic [31:0] c4 = '0, w4 = '0;
  logic [11:0] sval4, ms4;
  logic [15:0] sidx4, mi4;
  logic start8 = 0, v8 = 0, sl8 = 0, rdy8, sv8, dn8, bz8;
  logic [63:0] c8 = '0, w8 = '0;
  logic [13:0] sval8, ms8;
  logic [15:0] sidx8, mi8;

  sad_stream_min dut4 (
    .clk(clk), .rst(rst), .start(start4), .in_valid(v4), .in_ready(rdy4),
    .crop_row(c4), .win_row(w4), .search_last(sl4), .sad_val(sval4), .sad_valid(sv4),
    .sad_idx(sidx4), .min_sad(ms4), .min_idx(mi4), .done(dn4), .busy(bz4));
  sad_stream_min #(.BLK_W(8), .BLK_H(8), .PIX_W(8), .IDX_W(16)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .in_valid(v8), .in_ready(rdy8),
    .crop_row(c8), .win_row(w8), .search_last(sl8), .sad_val(sval8), .sad_valid(sv8),
    .sad_idx(sidx8), .min_sad(ms8), .min_idx(mi8), .done(dn8), .busy(bz8));

  int total = 0, bad = 0, cyc = 0, last4 = 0, gap4 = 0;
  int cp[64], wp[64];
  int q_sad4[$], q_idx4[$], q_min4[$], q_mi4[$];
  int q_sad8[$], q_idx8[$], q_min8[$], q_mi8[$];
  int cand[2], mn[2], mni[2];
  int crop_t[16] = '{126,91,45,122, 254,226,63,98, 138,124,235,235, 54,225,68,162};
  int win_t[16]  = '{13,95,197,122, 148,82,222,129, 144,18,74,206, 61,220,32,0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int ref_sad(input int n);
    int s = 0;
    for (int i = 0; i < n*n; i++) s += (cp[i] > wp[i]) ? cp[i] - wp[i] : wp[i] - cp[i];
    return s;
  endfunction

  task automatic load_1221();
    for (int i = 0; i < 16; i++) begin cp[i] = crop_t[i]; wp[i] = win_t[i]; end
  endtask

  task automatic fill_const(input int a, input int b);
    for (int i = 0; i < 64; i++) begin cp[i] = a; wp[i] = b; end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 64; i++) begin cp[i] = $urandom_range(255); wp[i] = $urandom_range(255); end
  endtask

  task automatic do_start(input int w);
    if (w != 0) start8 = 1; else start4 = 1;
    @(posedge clk); #1;
    start4 = 0; start8 = 0;
    cand[w] = 0; mn[w] = (w != 0) ? 16383 : 4095; mni[w] = 0;
    chk("busy_after_start", (w != 0) ? bz8 : bz4, 1);
  endtask

  task automatic send(input int w, input int rows, input bit last, input int bub, input bit poke);
    int n, s;
    n = (w != 0) ? 8 : 4;
    for (int r = 0; r < rows; r++) begin
      while (bub > 0 && $urandom_range(99) < bub) begin @(posedge clk); #1; end
      for (int c = 0; c < n; c++) begin
        if (w != 0) begin c8[c*8 +: 8] = 8'(cp[r*n+c]); w8[c*8 +: 8] = 8'(wp[r*n+c]); end
        else begin c4[c*8 +: 8] = 8'(cp[r*n+c]); w4[c*8 +: 8] = 8'(wp[r*n+c]); end
      end
      if (w != 0) begin v8 = 1; sl8 = (r == n-1) ? last : 1'($urandom_range(1)); end
      else begin
        v4 = 1; sl4 = (r == n-1) ? last : 1'($urandom_range(1));
        if (poke && r == 2) start4 = 1;
      end
      chk("ready_run", (w != 0) ? rdy8 : rdy4, 1);
      @(posedge clk); #1;
      v4 = 0; v8 = 0; sl4 = 0; sl8 = 0; start4 = 0;
    end
    if (rows == n) begin
      s = ref_sad(n);
      if (w != 0) begin q_sad8.push_back(s); q_idx8.push_back(cand[w]); end
      else begin q_sad4.push_back(s); q_idx4.push_back(cand[w]); end
      if (s < mn[w]) begin mn[w] = s; mni[w] = cand[w]; end
      cand[w] = (cand[w] + 1) % 65536;
    end
  endtask

  task automatic finish(input int w);
    if (w != 0) begin q_min8.push_back(mn[w]); q_mi8.push_back(mni[w]); end
    else begin q_min4.push_back(mn[w]); q_mi4.push_back(mni[w]); end
    @(posedge clk); #1;
    chk("sad_valid_latency", (w != 0) ? sv8 : sv4, 1);
    chk("drain_ready", (w != 0) ? rdy8 : rdy4, 0);
    chk("done_early", (w != 0) ? dn8 : dn4, 0);
    chk("drain_busy", (w != 0) ? bz8 : bz4, 1);
    @(posedge clk); #1;
    chk("done_pulse", (w != 0) ? dn8 : dn4, 1);
    chk("busy_end", (w != 0) ? bz8 : bz4, 0);
    chk("idle_ready", (w != 0) ? rdy8 : rdy4, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (sv4) begin
        gap4 = cyc - last4; last4 = cyc;
        if (q_sad4.size() == 0) chk("sad4_unexpected", 1, 0);
        else begin chk("sad4", sval4, q_sad4.pop_front()); chk("idx4", sidx4, q_idx4.pop_front()); end
      end
      if (dn4) begin
        if (q_min4.size() == 0) chk("done4_unexpected", 1, 0);
        else begin chk("min4", ms4, q_min4.pop_front()); chk("minidx4", mi4, q_mi4.pop_front()); end
      end
      if (sv8) begin
        if (q_sad8.size() == 0) chk("sad8_unexpected", 1, 0);
        else begin chk("sad8", sval8, q_sad8.pop_front()); chk("idx8", sidx8, q_idx8.pop_front()); end
      end
      if (dn8) begin
        if (q_min8.size() == 0) chk("done8_unexpected", 1, 0);
        else begin chk("min8", ms8, q_min8.pop_front()); chk("minidx8", mi8, q_mi8.pop_front()); end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sadval", sval4, 0); chk("rst_sadvalid", sv4, 0); chk("rst_sadidx", sidx4, 0);
    chk("rst_minsad", ms4, 4095); chk("rst_minidx", mi4, 0); chk("rst_done", dn4, 0);
    chk("rst_busy", bz4, 0); chk("rst_ready", rdy4, 0); chk("rst_minsad8", ms8, 16383);
    rst = 0;
    @(posedge clk); #1;
    // directed 1221 block
    do_start(0); load_1221(); send(0, 4, 1, 0, 0); finish(0);
    chk("d1221_sad", sval4, 1221); chk("d1221_idx", sidx4, 0);
    chk("d1221_min", ms4, 1221); chk("d1221_minidx", mi4, 0);
    // saturation and identical blocks
    do_start(0); fill_const(255, 0); send(0, 4, 1, 0, 0); finish(0);
    chk("sat_sad", sval4, 4080); chk("sat_min", ms4, 4080);
    do_start(0); fill_rand(); for (int i = 0; i < 64; i++) wp[i] = cp[i]; send(0, 4, 1, 0, 0); finish(0);
    chk("ident_sad", sval4, 0); chk("ident_min", ms4, 0);
    // 500, 300, 300 back to back: the tie keeps index 1
    do_start(0);
    fill_const(0, 0); wp[0] = 250; wp[1] = 250; send(0, 4, 0, 0, 0);
    fill_const(0, 0); wp[0] = 150; wp[1] = 150; send(0, 4, 0, 0, 0);
    fill_const(0, 0); wp[5] = 150; wp[9] = 150; send(0, 4, 1, 0, 0);
    finish(0);
    chk("tie_min", ms4, 300); chk("tie_minidx", mi4, 1); chk("tie_lastidx", sidx4, 2); chk("tie_gap", gap4, 4);
    // bubbles plus a Start poke mid-search
    do_start(0);
    fill_rand(); send(0, 4, 0, 40, 1);
    load_1221(); send(0, 4, 1, 40, 1);
    finish(0);
    chk("bub_sad", sval4, 1221); chk("bub_idx", sidx4, 1);
    // reset two rows into a candidate
    do_start(0); load_1221(); send(0, 2, 0, 0, 0);
    rst = 1; #1;
    chk("mid_rst_sadval", sval4, 0); chk("mid_rst_minsad", ms4, 4095); chk("mid_rst_busy", bz4, 0);
    chk("mid_rst_ready", rdy4, 0); chk("mid_rst_sadidx", sidx4, 0); chk("mid_rst_done", dn4, 0);
    @(posedge clk); #1; rst = 0;
    @(posedge clk); #1;
    do_start(0); load_1221(); send(0, 4, 1, 0, 0); finish(0);
    chk("fresh_sad", sval4, 1221); chk("fresh_idx", sidx4, 0);
    // random 4x4 search
    do_start(0);
    for (int i = 0; i < 20; i++) begin fill_rand(); send(0, 4, i == 19, 20, 0); end
    finish(0);
    // 8x8 instance
    do_start(1); fill_const(255, 0); send(1, 8, 1, 0, 0); finish(1);
    chk("sat8_sad", sval8, 16320); chk("sat8_min", ms8, 16320);
    do_start(1);
    for (int i = 0; i < 200; i++) begin fill_rand(); send(1, 8, i == 199, 10, 0); end
    finish(1);
    repeat (3) @(posedge clk);
    #1;
    chk("left_sad4", q_sad4.size(), 0); chk("left_min4", q_min4.size(), 0);
    chk("left_sad8", q_sad8.size(), 0); chk("left_min8", q_min8.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sad_stream_min.md
Name: sad_stream_min

Overview:
- Sequential, parametrised successor to the single-shot 4x4 SAD calculator.
- Accepts one row of crop pixels and one row of window pixels per beat, under a valid/ready handshake. It accumulates a full BLK_W x BLK_H SAD for each candidate window.
- Tracks the minimum SAD and its candidate index across a search.
- Sits between the frame/window fetch logic and the motion-vector result register.

Parameters:
- BLK_W, 4, pixels per row.
- BLK_H, 4, rows per block (>=2).
- PIX_W, 8, bits per unsigned pixel.
- IDX_W, 16, candidate index width.
- Derived (localparam): SAD_W = PIX_W + clog2(BLK_W*BLK_H). This gives 12 at the defaults, so the worst case 16*255 = 4080 fits.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Start  in  1  begin new search; sampled only in IDLE.
- InValid  in  1  row beat valid.
- InReady  out  1  row beat accepted when InValid && InReady.
- CropRow  in  BLK_W*PIX_W  crop pixels; lane c at [c*PIX_W +: PIX_W].
- WinRow  in  BLK_W*PIX_W  window pixels, same packing.
- SearchLast  in  1  marks the final candidate; sampled only on a candidate's last row.
- SADVal  out  SAD_W  SAD of most recently completed candidate.
- SADValid  out  1  one-cycle pulse when SADVal updates.
- SADIdx  out  IDX_W  index of candidate in SADVal.
- MinSAD  out  SAD_W  running minimum for current search.
- MinIdx  out  IDX_W  index of MinSAD candidate.
- Done  out  1  one-cycle pulse, search finished; MinSAD/MinIdx final.
- Busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, Rst=1): state IDLE; InReady=0; SADVal=0; SADValid=0; SADIdx=0; MinSAD=all ones; MinIdx=0; Done=0; Busy=0; row counter, candidate counter and pipeline registers cleared. Reset mid-search abandons the search with no Done.
- States and transitions:
  - IDLE: Start=1 -> RUN; MinSAD := all ones; MinIdx := 0; candidate counter := 0.
  - RUN: InReady=1. Row beats are accepted back to back, one per cycle, with no bubble between candidates. Accepting row BLK_H-1 with SearchLast=1 -> DRAIN.
  - DRAIN: InReady=0; lasts exactly 2 cycles while the pipeline empties. Done pulses in the final DRAIN cycle's next edge, then -> IDLE.
  - Start is ignored outside IDLE.
- Pipeline: a beat is accepted at edge k.
  - Stage 1 (edge k): register the row sum, the sum over lanes of |Crop-Win|. The absolute difference is unsigned, computed in PIX_W+1 bits.
  - Stage 2 (edge k+1): accumulator += row sum. On the candidate's last row, stage 2 writes acc+rowsum to SADVal, pulses SADValid, loads SADIdx, and clears the accumulator for the next candidate in the same edge.
  - Min update (edge k+2): if SADVal < MinSAD (strict), load MinSAD/MinIdx. Ties keep the earlier index.
  - Done asserts at edge k+2 of the SearchLast row, so MinSAD/MinIdx are valid in the same cycle as Done.
- Row counter: 0..BLK_H-1, wraps to 0 after the last row. Candidate counter increments per completed candidate and wraps modulo 2^IDX_W.
- InValid=0 in RUN inserts bubbles; partial-block accumulation is held and nothing else changes.
- SearchLast on a non-final row is ignored.
- SADVal and SADIdx hold between pulses. MinSAD and MinIdx hold after Done until the next accepted Start.
- No overflow is possible by construction; all sums are unsigned SAD_W bits.

Test Plan:
- Default params, one candidate with SearchLast.
  - Crop rows (126,91,45,122)(254,226,63,98)(138,124,235,235)(54,225,68,162).
  - Window rows (13,95,197,122)(148,82,222,129)(144,18,74,206)(61,220,32,0).
  - Expect SADVal=1221, SADIdx=0, MinSAD=1221, MinIdx=0, Done 2 cycles after the last beat, Busy then low.
- Saturation: crop all 255, window all 0 -> SADVal=4080 with no wrap; identical blocks -> SADVal=0.
- Three candidates back to back, no gaps, SADs 500, 300, 300 -> three SADValid pulses 4 cycles apart; MinSAD=300, MinIdx=1 (tie keeps earlier).
- Random InValid bubbles during the 1221 case -> identical SADVal; InReady low throughout DRAIN; Start pulsed mid-search has no effect.
- Rst asserted after 2 rows of a candidate -> all outputs return to reset values immediately. A new Start then 4 rows -> correct fresh SAD with SADIdx=0.
- Parameter sweep BLK_W=8, BLK_H=8, PIX_W=8 (SAD_W=14): all 255 vs 0 -> 16320. Compare against a bench reference model over 200 random candidates.
